// File: rtl/ssd_digit_capture.sv
`default_nettype none
// ============================================================================
// Module   : ssd_digit_capture
// Brief    : Debounces 7-segment patterns and assembles them into a phone number.
// Revision : 1.0
// ============================================================================
module ssd_digit_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int NUM_DIGITS    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic [6:0]              seg_in,
    output logic [3:0]              digit_out,
    output logic                    digit_valid,
    output logic                    digit_error,
    output logic [4*NUM_DIGITS-1:0] number_out,
    output logic [3:0]              digit_count,
    output logic                    number_done
);

    localparam int         NW          = 4 * NUM_DIGITS;
    localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0] STABLE_MAX  = 4'(STABLE_CYCLES);
    localparam logic [3:0] DIGITS_MAX  = 4'(NUM_DIGITS);

    localparam logic [1:0] WAIT_BLANK = 2'd0;
    localparam logic [1:0] WAIT_DIGIT = 2'd1;
    localparam logic [1:0] HELD       = 2'd2;

    logic [6:0]    seg_q;
    logic [3:0]    stab_q, stab_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    digit_q, digit_d;
    logic          valid_q, valid_d;
    logic          error_q, error_d;
    logic [NW-1:0] number_q, number_d;
    logic [3:0]    count_q, count_d;
    logic          done_q, done_d;

    logic          w_same;
    logic          w_accept;
    logic          w_blank;
    logic          w_known;
    logic [3:0]    w_bcd;

    assign w_same   = (seg_in == seg_q);
    // Acceptance fires on the single edge where the counter steps to its limit.
    assign w_accept = w_same && (stab_q == STABLE_LAST);
    assign w_blank  = (seg_q == 7'h00);
    assign stab_d   = !w_same ? 4'd0 : ((stab_q == STABLE_MAX) ? stab_q : stab_q + 4'd1);

    always_comb begin
        w_known = 1'b1;
        w_bcd   = 4'hF;
        case (seg_q)
            7'h7E:   w_bcd = 4'd0;
            7'h30:   w_bcd = 4'd1;
            7'h6D:   w_bcd = 4'd2;
            7'h79:   w_bcd = 4'd3;
            7'h33:   w_bcd = 4'd4;
            7'h5B:   w_bcd = 4'd5;
            7'h5F:   w_bcd = 4'd6;
            7'h70:   w_bcd = 4'd7;
            7'h7F:   w_bcd = 4'd8;
            7'h7B:   w_bcd = 4'd9;
            default: w_known = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = WAIT_BLANK;
        end else if (w_accept) begin
            case (state_q)
                WAIT_BLANK: if (w_blank)  state_d = WAIT_DIGIT;
                WAIT_DIGIT: if (!w_blank) state_d = HELD;
                HELD:       if (w_blank)  state_d = WAIT_DIGIT;
                default:                  state_d = WAIT_BLANK;
            endcase
        end
    end

    always_comb begin
        digit_d  = digit_q;
        number_d = number_q;
        count_d  = count_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        done_d   = 1'b0;
        if (clr) begin
            number_d = '0;
            count_d  = 4'd0;
        end else if (w_accept && (state_q == WAIT_DIGIT) && !w_blank) begin
            if (w_known) begin
                digit_d = w_bcd;
                valid_d = 1'b1;
                // A full number is replaced rather than extended.
                if (count_q == DIGITS_MAX) begin
                    number_d = {{(NW-4){1'b0}}, w_bcd};
                    count_d  = 4'd1;
                    done_d   = (DIGITS_MAX == 4'd1);
                end else begin
                    number_d = {number_q[NW-5:0], w_bcd};
                    count_d  = count_q + 4'd1;
                    done_d   = ((count_q + 4'd1) == DIGITS_MAX);
                end
            end else begin
                digit_d = 4'hF;
                error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q    <= 7'h00;
            stab_q   <= 4'd0;
            digit_q  <= 4'd0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            number_q <= '0;
            count_q  <= 4'd0;
            done_q   <= 1'b0;
        end else begin
            seg_q    <= seg_in;
            stab_q   <= stab_d;
            digit_q  <= digit_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            number_q <= number_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

    assign digit_out   = digit_q;
    assign digit_valid = valid_q;
    assign digit_error = error_q;
    assign number_out  = number_q;
    assign digit_count = count_q;
    assign number_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ssd_digit_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssd_digit_capture
// Brief    : Scoreboard bench for the 7-segment digit capture block.
// Revision : 1.0
// ============================================================================
module tb_ssd_digit_capture;

    localparam int S = 4;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [6:0]  seg_in;
    logic [3:0]  digit_out;
    logic        digit_valid;
    logic        digit_error;
    logic [31:0] number_out;
    logic [3:0]  digit_count;
    logic        number_done;

    ssd_digit_capture #(.STABLE_CYCLES(S), .NUM_DIGITS(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .seg_in      (seg_in),
        .digit_out   (digit_out),
        .digit_valid (digit_valid),
        .digit_error (digit_error),
        .number_out  (number_out),
        .digit_count (digit_count),
        .number_done (number_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [3:0]  dig;
        logic [31:0] num;
        logic [3:0]  cnt;
        bit          done;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] m_num  = 32'h0;
    int          m_cnt  = 0;
    bit          prev_pulse = 1'b0;

    // One clock edge, then consume any pulse from the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checks++; errors++;
            $display("FAIL missing_pulse: no pulse by cycle %0d, required at cycle %0d", cyc, e.cyc);
        end
        if (digit_valid || digit_error) begin
            checks++;
            if (prev_pulse) begin
                errors++;
                $display("FAIL back_to_back_pulse: pulse high on consecutive cycles at %0d", cyc);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: cycle %0d valid=%b error=%b digit=%h, required no pulse",
                         cyc, digit_valid, digit_error, digit_out);
            end else begin
                e = sb.pop_front();
                if ({digit_valid, digit_error, digit_out, number_out, digit_count, number_done}
                        !== {!e.is_err, e.is_err, e.dig, e.num, e.cnt, e.done} || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pulse: got cyc=%0d v=%b e=%b dig=%h num=%h cnt=%0d done=%b, required cyc=%0d v=%b e=%b dig=%h num=%h cnt=%0d done=%b",
                             cyc, digit_valid, digit_error, digit_out, number_out, digit_count, number_done,
                             e.cyc, !e.is_err, e.is_err, e.dig, e.num, e.cnt, e.done);
                end
            end
        end else if (number_done) begin
            checks++; errors++;
            $display("FAIL done_without_valid: number_done=1 at cycle %0d, required 0", cyc);
        end
        prev_pulse = digit_valid || digit_error;
    endtask

    task automatic apply(input logic [6:0] pat, input int n);
        seg_in = pat;
        repeat (n) tick();
    endtask

    task automatic expect_valid(input logic [3:0] bcd);
        exp_t e;
        if (m_cnt == N) begin
            m_num = {28'h0, bcd};
            m_cnt = 1;
        end else begin
            m_num = {m_num[27:0], bcd};
            m_cnt = m_cnt + 1;
        end
        e.is_err = 1'b0; e.dig = bcd; e.num = m_num; e.cnt = 4'(m_cnt);
        e.done = (m_cnt == N); e.cyc = cyc + 1 + S;
        sb.push_back(e);
    endtask

    task automatic expect_error();
        exp_t e;
        e.is_err = 1'b1; e.dig = 4'hF; e.num = m_num; e.cnt = 4'(m_cnt);
        e.done = 1'b0; e.cyc = cyc + 1 + S;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b0; clr = 1'b0; seg_in = 7'h7F;
        #2 rst = 1'b1;
        #1;
        checks++; if (digit_out !== 4'h0)    begin errors++; $display("FAIL reset_digit_out: got %h required 0", digit_out); end
        checks++; if (digit_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b required 0", digit_valid); end
        checks++; if (digit_error !== 1'b0)  begin errors++; $display("FAIL reset_error: got %b required 0", digit_error); end
        checks++; if (number_out !== 32'h0)  begin errors++; $display("FAIL reset_number: got %h required 0", number_out); end
        checks++; if (digit_count !== 4'h0)  begin errors++; $display("FAIL reset_count: got %0d required 0", digit_count); end
        checks++; if (number_done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b required 0", number_done); end
        seg_in = 7'h00;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        apply(7'h00, 6);
        expect_valid(4'd5);
        apply(7'h5B, 6);
        checks++; if (digit_out !== 4'd5)        begin errors++; $display("FAIL single_digit: got %h required 5", digit_out); end
        checks++; if (digit_count !== 4'd1)      begin errors++; $display("FAIL single_count: got %0d required 1", digit_count); end
        checks++; if (number_out[3:0] !== 4'd5)  begin errors++; $display("FAIL single_number: got %h required 5", number_out[3:0]); end
    endtask

    task automatic test_full_number();
        logic [6:0] pats [7];
        logic [3:0] bcds [7];
        pats = '{7'h5B, 7'h5B, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B};
        bcds = '{4'd5, 4'd5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        for (int i = 0; i < 7; i++) begin
            apply(7'h00, 6);
            expect_valid(bcds[i]);
            apply(pats[i], 6);
        end
        checks++; if (number_out !== 32'h55512345) begin errors++; $display("FAIL full_number: got %h required 55512345", number_out); end
        checks++; if (digit_count !== 4'd8)        begin errors++; $display("FAIL full_count: got %0d required 8", digit_count); end
    endtask

    task automatic test_wrap();
        apply(7'h00, 6);
        expect_valid(4'd3);
        apply(7'h79, 6);
        checks++; if (number_out !== 32'h3)  begin errors++; $display("FAIL wrap_number: got %h required 00000003", number_out); end
        checks++; if (digit_count !== 4'd1)  begin errors++; $display("FAIL wrap_count: got %0d required 1", digit_count); end
    endtask

    task automatic test_glitch();
        apply(7'h00, 6);
        apply(7'h7E, 3);
        apply(7'h00, 6);
        apply(7'h7F, 1);
        apply(7'h00, 6);
        checks++; if (digit_count !== 4'd1)  begin errors++; $display("FAIL glitch_count: got %0d required 1", digit_count); end
        checks++; if (number_out !== 32'h3)  begin errors++; $display("FAIL glitch_number: got %h required 3", number_out); end
    endtask

    task automatic test_invalid();
        apply(7'h00, 6);
        expect_error();
        apply(7'h0F, 6);
        checks++; if (digit_out !== 4'hF)    begin errors++; $display("FAIL invalid_digit: got %h required F", digit_out); end
        checks++; if (number_out !== 32'h3)  begin errors++; $display("FAIL invalid_number: got %h required 3", number_out); end
        apply(7'h30, 6);
        apply(7'h00, 6);
        expect_valid(4'd1);
        apply(7'h30, 6);
        checks++; if (number_out !== 32'h31) begin errors++; $display("FAIL after_invalid_number: got %h required 31", number_out); end
    endtask

    task automatic test_clr();
        apply(7'h00, 6);
        apply(7'h5B, 2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_num = 32'h0; m_cnt = 0;
        checks++; if (digit_count !== 4'd0)  begin errors++; $display("FAIL clr_count: got %0d required 0", digit_count); end
        checks++; if (number_out !== 32'h0)  begin errors++; $display("FAIL clr_number: got %h required 0", number_out); end
        apply(7'h5B, 6);
        apply(7'h00, 6);
        apply(7'h79, S);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        apply(7'h79, 4);
        checks++; if (digit_count !== 4'd0)  begin errors++; $display("FAIL clr_wins_count: got %0d required 0", digit_count); end
        apply(7'h00, 6);
        expect_valid(4'd1);
        apply(7'h30, 6);
        checks++; if (number_out !== 32'h1)  begin errors++; $display("FAIL after_clr_number: got %h required 1", number_out); end
    endtask

    task automatic test_async_reset();
        apply(7'h00, 6);
        expect_valid(4'd1);
        apply(7'h30, 6);
        #2 rst = 1'b1;
        #1;
        checks++; if (number_out !== 32'h0)  begin errors++; $display("FAIL async_number: got %h required 0", number_out); end
        checks++; if (digit_count !== 4'd0)  begin errors++; $display("FAIL async_count: got %0d required 0", digit_count); end
        checks++; if (digit_out !== 4'd0)    begin errors++; $display("FAIL async_digit: got %h required 0", digit_out); end
        tick();
        rst = 1'b0;
        m_num = 32'h0; m_cnt = 0;
        apply(7'h30, 6);
        checks++; if (digit_count !== 4'd0)  begin errors++; $display("FAIL async_held_count: got %0d required 0", digit_count); end
        apply(7'h00, 6);
        expect_valid(4'd1);
        apply(7'h30, 6);
        checks++; if (digit_count !== 4'd1)  begin errors++; $display("FAIL async_recover_count: got %0d required 1", digit_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_number();
        test_wrap();
        test_glitch();
        test_invalid();
        test_clr();
        test_async_reset();
        apply(7'h00, 2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ssd_digit_capture.md
SSD_DIGIT_CAPTURE -- requirements
Module: ssd_digit_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive clocks a segment pattern must hold before acceptance (legal range 2..15).
REQ-002 Parameter NUM_DIGITS, default 8: digits per phone number.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 clr  input  1  synchronous clear of digit count and number register.
REQ-006 seg_in  input  7  segment pattern, bit6..bit0 = a,b,c,d,e,f,g, 1 = segment lit.
REQ-007 digit_out  output  4  BCD of last accepted digit (4'hF after an invalid pattern).
REQ-008 digit_valid  output  1  one-cycle pulse, valid digit accepted.
REQ-009 digit_error  output  1  one-cycle pulse, stable non-blank pattern not in the digit table.
REQ-010 number_out  output  4*NUM_DIGITS  captured digits; most recent in [3:0].
REQ-011 digit_count  output  4  number of digits in number_out (0..NUM_DIGITS).
REQ-012 number_done  output  1  one-cycle pulse when digit_count reaches NUM_DIGITS.

Function
REQ-013 Decode table: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B (hex); 00 = blank; every other pattern is invalid.
REQ-014 seg_in is registered once (seg_q); a stability counter counts consecutive clocks with unchanged seg_q, resets to 0 on any change, saturates at STABLE_CYCLES.
REQ-015 A pattern is accepted on the clock its stability counter reaches STABLE_CYCLES; a pattern applied before edge k and held produces its output pulse in the cycle after edge k+STABLE_CYCLES (latency STABLE_CYCLES+1 clocks).
REQ-016 Glitches shorter than STABLE_CYCLES clocks produce no pulse and do not change state.
REQ-017 FSM states: WAIT_BLANK, WAIT_DIGIT, HELD.
REQ-018 After reset, state is WAIT_BLANK; an accepted blank moves it to WAIT_DIGIT; non-blank patterns are ignored in WAIT_BLANK.
REQ-019 WAIT_DIGIT + accepted valid digit: digit_out <= BCD, digit_valid pulse, number_out <= {number_out[4*NUM_DIGITS-5:0], BCD}, digit_count+1, state HELD.
REQ-020 WAIT_DIGIT + accepted invalid pattern: digit_out <= 4'hF, digit_error pulse, number_out and digit_count unchanged, state HELD.
REQ-021 HELD + accepted blank: state WAIT_DIGIT; repeated identical digits therefore require an intervening stable blank.
REQ-022 number_done pulses in the same cycle as the digit_valid that brings digit_count to NUM_DIGITS.
REQ-023 Valid digit accepted while digit_count == NUM_DIGITS: number_out <= {zeros, BCD}, digit_count <= 1 (new number).
REQ-024 clr: digit_count <= 0, number_out <= 0, state WAIT_BLANK, no pulses in that cycle; clr wins over a simultaneous acceptance.
REQ-025 Pulse outputs are registered and never high for two consecutive cycles.

Reset
REQ-026 rst asserted: immediately, without a clock edge, digit_out=0, digit_valid=0, digit_error=0, number_out=0, digit_count=0, number_done=0, seg_q=0, stability counter=0, state WAIT_BLANK.
REQ-027 rst mid-capture discards partial number; after release a stable blank is required before the next digit.

Verification
REQ-028 Reset, blank 6 clks, 5B held 6 clks -> digit_valid one cycle at 5 clks after 5B applied, digit_out=5, digit_count=1, number_out[3:0]=5.
REQ-029 Blank/digit sequence 5,5,5,1,2,3,4,5 each separated by 6-clk blanks -> number_done one cycle with last digit_valid, number_out=32'h55512345, digit_count=8.
REQ-030 Blank then 7E held 3 clks, then blank -> no digit_valid, digit_count unchanged.
REQ-031 Blank then 0F held 6 clks -> digit_error one cycle, digit_out=F, number_out unchanged; then 30 held without blank -> no pulse until blank then 30.
REQ-032 After 8 digits, blank then 79 -> number_out=32'h00000003, digit_count=1; clr mid-digit -> digit_count=0, number_out=0.
REQ-033 rst asserted between clock edges during a held digit -> all outputs 0 before next edge; release with 30 still held -> no pulse until blank then 30.
